// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control sequencer:
// encodings, control-word layout, sequencer states and trap causes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_TRAP  = 3'd4
    } state_t;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // ALU operation codes
    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SLL  = 4'b1110;

    // ALU B-operand select
    localparam logic [1:0] M4_RT   = 2'b00;
    localparam logic [1:0] M4_ZIMM = 2'b01;
    localparam logic [1:0] M4_SIMM = 2'b10;
    localparam logic [1:0] M4_ZERO = 2'b11;

    // Register-file destination select
    localparam logic [1:0] M8_RD = 2'b00;
    localparam logic [1:0] M8_RT = 2'b01;
    localparam logic [1:0] M8_RA = 2'b10;

    // Trap causes
    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_DMEM_TO = 2'b10;

    // Decoded control word; M5 is absent because it depends on the taken flag
    typedef struct packed {
        logic [3:0] aluc;
        logic       m1;
        logic       m2;
        logic       m3;
        logic [1:0] m4;
        logic       m6;
        logic       m7;
        logic [1:0] m8;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       branch_ne;
        logic       writes_rf;
        logic       illegal;
    } ctrl_word_t;

    localparam ctrl_word_t CW_NOP = '{
        aluc: ALU_ADDU, m1: 1'b0, m2: 1'b0, m3: 1'b0, m4: M4_RT,
        m6: 1'b0, m7: 1'b1, m8: M8_RD, is_load: 1'b0, is_store: 1'b0,
        is_branch: 1'b0, branch_ne: 1'b0, writes_rf: 1'b0, illegal: 1'b0
    };

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control/handshake bundle between the sequencer (master) and the
// datapath plus memories (slave).
interface cpu_ctrl_fsm_if;
    logic [31:0] imem_out;
    logic        im_ready;
    logic        dm_ready;
    logic        Z;
    logic        IM_R;
    logic [31:0] ir_out;
    logic        PC_W;
    logic        RF_W;
    logic [3:0]  ALUC;
    logic        M1;
    logic        M2;
    logic        M3;
    logic [1:0]  M4;
    logic        M5;
    logic        M6;
    logic        M7;
    logic [1:0]  M8;
    logic        CS;
    logic        DM_R;
    logic        DM_W;
    logic        trap;
    logic [1:0]  trap_cause;

    modport master (
        input  imem_out, im_ready, dm_ready, Z,
        output IM_R, ir_out, PC_W, RF_W, ALUC, M1, M2, M3, M4, M5, M6, M7, M8,
               CS, DM_R, DM_W, trap, trap_cause
    );

    modport slave (
        output imem_out, im_ready, dm_ready, Z,
        input  IM_R, ir_out, PC_W, RF_W, ALUC, M1, M2, M3, M4, M5, M6, M7, M8,
               CS, DM_R, DM_W, trap, trap_cause
    );
endinterface

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: IR opcode/funct fields to control word.
// Any encoding outside the 31-instruction subset is flagged illegal.
module cpu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_word_t cw
);

    // Map opcode/funct onto selects, ALU op and instruction class
    always_comb begin
        cw = CW_NOP;
        case (opcode)
            OP_RTYPE: begin
                cw.writes_rf = 1'b1;
                case (funct)
                    FN_ADD:  cw.aluc = ALU_ADD;
                    FN_ADDU: cw.aluc = ALU_ADDU;
                    FN_SUB:  cw.aluc = ALU_SUB;
                    FN_SUBU: cw.aluc = ALU_SUBU;
                    FN_AND:  cw.aluc = ALU_AND;
                    FN_OR:   cw.aluc = ALU_OR;
                    FN_XOR:  cw.aluc = ALU_XOR;
                    FN_NOR:  cw.aluc = ALU_NOR;
                    FN_SLT:  cw.aluc = ALU_SLT;
                    FN_SLTU: cw.aluc = ALU_SLTU;
                    FN_SLLV: cw.aluc = ALU_SLL;
                    FN_SRLV: cw.aluc = ALU_SRL;
                    FN_SRAV: cw.aluc = ALU_SRA;
                    FN_SLL:  begin cw.aluc = ALU_SLL; cw.m3 = 1'b1; end
                    FN_SRL:  begin cw.aluc = ALU_SRL; cw.m3 = 1'b1; end
                    FN_SRA:  begin cw.aluc = ALU_SRA; cw.m3 = 1'b1; end
                    FN_JR:   begin cw.writes_rf = 1'b0; cw.m1 = 1'b1; cw.m6 = 1'b1; end
                    default: begin cw.writes_rf = 1'b0; cw.illegal = 1'b1; end
                endcase
            end
            OP_J:     cw.m1 = 1'b1;
            OP_JAL:   begin cw.m1 = 1'b1; cw.m8 = M8_RA; cw.m7 = 1'b0; cw.writes_rf = 1'b1; end
            OP_BEQ:   begin cw.aluc = ALU_SUBU; cw.is_branch = 1'b1; end
            OP_BNE:   begin cw.aluc = ALU_SUBU; cw.is_branch = 1'b1; cw.branch_ne = 1'b1; end
            OP_ADDI:  begin cw.aluc = ALU_ADD;  cw.m4 = M4_SIMM; cw.m8 = M8_RT; cw.writes_rf = 1'b1; end
            OP_ADDIU: begin cw.aluc = ALU_ADDU; cw.m4 = M4_SIMM; cw.m8 = M8_RT; cw.writes_rf = 1'b1; end
            OP_SLTI:  begin cw.aluc = ALU_SLT;  cw.m4 = M4_SIMM; cw.m8 = M8_RT; cw.writes_rf = 1'b1; end
            OP_SLTIU: begin cw.aluc = ALU_SLTU; cw.m4 = M4_SIMM; cw.m8 = M8_RT; cw.writes_rf = 1'b1; end
            OP_ANDI:  begin cw.aluc = ALU_AND;  cw.m4 = M4_ZIMM; cw.m8 = M8_RT; cw.writes_rf = 1'b1; end
            OP_ORI:   begin cw.aluc = ALU_OR;   cw.m4 = M4_ZIMM; cw.m8 = M8_RT; cw.writes_rf = 1'b1; end
            OP_XORI:  begin cw.aluc = ALU_XOR;  cw.m4 = M4_ZIMM; cw.m8 = M8_RT; cw.writes_rf = 1'b1; end
            OP_LUI:   begin cw.aluc = ALU_LUI;  cw.m4 = M4_ZIMM; cw.m8 = M8_RT; cw.writes_rf = 1'b1; end
            OP_LW:    begin
                cw.m4 = M4_SIMM; cw.m8 = M8_RT; cw.m2 = 1'b1;
                cw.writes_rf = 1'b1; cw.is_load = 1'b1;
            end
            OP_SW:    begin cw.m4 = M4_SIMM; cw.is_store = 1'b1; end
            default:  cw.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH -> EXEC -> (MEM) -> WB, with a
// sticky TRAP state for illegal instructions and data-memory timeouts.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 16
)(
    input  logic           clk_in,
    input  logic           reset,
    cpu_ctrl_fsm_if.master bus
);

    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t          state_r;
    logic [31:0]     ir_r;
    logic            taken_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            trap_r;
    logic [1:0]      cause_r;
    ctrl_word_t      cw_s;
    logic            sel_on_s;
    logic [TO_W-1:0] to_cnt_nxt_s;

    cpu_decoder u_dec (
        .opcode (ir_r[31:26]),
        .funct  (ir_r[5:0]),
        .cw     (cw_s)
    );

    assign to_cnt_nxt_s = to_cnt_r + TO_ONE;

    // Sequencer state, instruction register, branch outcome, MEM timeout and trap status
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_FETCH;
            ir_r     <= 32'd0;
            taken_r  <= 1'b0;
            to_cnt_r <= '0;
            trap_r   <= 1'b0;
            cause_r  <= TC_NONE;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (bus.im_ready) begin
                        ir_r    <= bus.imem_out;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    taken_r  <= cw_s.is_branch & (cw_s.branch_ne ? ~bus.Z : bus.Z);
                    to_cnt_r <= '0;
                    if (cw_s.illegal) begin
                        state_r <= ST_TRAP;
                        trap_r  <= 1'b1;
                        cause_r <= TC_ILLEGAL;
                    end else if (cw_s.is_load | cw_s.is_store) begin
                        state_r <= ST_MEM;
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_MEM: begin
                    // A ready arriving on the final counted cycle still completes the access
                    to_cnt_r <= to_cnt_nxt_s;
                    if (bus.dm_ready) begin
                        state_r <= ST_WB;
                    end else if (to_cnt_nxt_s >= TO_LIMIT) begin
                        state_r <= ST_TRAP;
                        trap_r  <= 1'b1;
                        cause_r <= TC_DMEM_TO;
                    end
                end
                ST_WB: begin
                    to_cnt_r <= '0;
                    state_r  <= ST_FETCH;
                end
                ST_TRAP: begin
                    state_r <= ST_TRAP;
                    trap_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_TRAP;
                    trap_r  <= 1'b1;
                    cause_r <= TC_ILLEGAL;
                end
            endcase
        end
    end

    // Selects and ALU op are only meaningful while an instruction is in flight
    always_comb begin
        sel_on_s = 1'b0;
        case (state_r)
            ST_EXEC, ST_MEM, ST_WB: sel_on_s = 1'b1;
            default:                sel_on_s = 1'b0;
        endcase
    end

    assign bus.ALUC = sel_on_s ? cw_s.aluc : 4'b0000;
    assign bus.M1   = sel_on_s & cw_s.m1;
    assign bus.M2   = sel_on_s & cw_s.m2;
    assign bus.M3   = sel_on_s & cw_s.m3;
    assign bus.M4   = sel_on_s ? cw_s.m4 : 2'b00;
    assign bus.M5   = sel_on_s & (cw_s.is_branch ? ~taken_r : 1'b1);
    assign bus.M6   = sel_on_s & cw_s.m6;
    assign bus.M7   = sel_on_s & cw_s.m7;
    assign bus.M8   = sel_on_s ? cw_s.m8 : 2'b00;

    // The reset term keeps the fetch request quiet while reset is held
    assign bus.IM_R = reset & (state_r == ST_FETCH);
    assign bus.PC_W = (state_r == ST_WB);
    assign bus.RF_W = (state_r == ST_WB) & cw_s.writes_rf;
    assign bus.CS   = (state_r == ST_MEM);
    assign bus.DM_R = (state_r == ST_MEM) & cw_s.is_load;
    assign bus.DM_W = (state_r == ST_MEM) & cw_s.is_store;

    assign bus.ir_out     = ir_r;
    assign bus.trap       = trap_r;
    assign bus.trap_cause = cause_r;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed testbench for cpu_ctrl_fsm (MEM_TIMEOUT reduced to 4).
module tb_cpu_ctrl_fsm;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    int   test_cnt = 0;
    int   fail_cnt = 0;

    cpu_ctrl_fsm_if bus ();

    cpu_ctrl_fsm #(.MEM_TIMEOUT(4), .TO_W(16)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.im_ready = 1'b0; bus.dm_ready = 1'b0; bus.Z = 1'b0; bus.imem_out = 32'd0;
        repeat (3) tick();
        test_cnt++; if (bus.IM_R !== 1'b0) begin fail_cnt++; $display("FAIL rst_im_r: got %b want 0", bus.IM_R); end
        test_cnt++; if ({bus.PC_W, bus.RF_W, bus.CS, bus.DM_R, bus.DM_W} !== 5'b00000) begin fail_cnt++; $display("FAIL rst_strobes: got %b want 00000", {bus.PC_W, bus.RF_W, bus.CS, bus.DM_R, bus.DM_W}); end
        test_cnt++; if ({bus.ALUC, bus.M1, bus.M2, bus.M3, bus.M4, bus.M5, bus.M6, bus.M7, bus.M8} !== 15'd0) begin fail_cnt++; $display("FAIL rst_selects: got %b want 0", {bus.ALUC, bus.M1, bus.M2, bus.M3, bus.M4, bus.M5, bus.M6, bus.M7, bus.M8}); end
        test_cnt++; if ({bus.trap, bus.trap_cause} !== 3'b000) begin fail_cnt++; $display("FAIL rst_trap: got %b want 000", {bus.trap, bus.trap_cause}); end
        test_cnt++; if (bus.ir_out !== 32'd0) begin fail_cnt++; $display("FAIL rst_ir: got %h want 0", bus.ir_out); end
        reset = 1'b1;
        #1;
        test_cnt++; if (bus.IM_R !== 1'b1) begin fail_cnt++; $display("FAIL rst_release_im_r: got %b want 1", bus.IM_R); end
    endtask

    // ALU instruction decode table: 3-cycle latency, selects in EXEC, RF_W/PC_W in WB
    task automatic test_alu_decode();
        logic [31:0] ins [0:5];
        logic [3:0]  e_aluc [0:5];
        logic        e_m3 [0:5];
        logic [1:0]  e_m4 [0:5];
        logic [1:0]  e_m8 [0:5];
        ins    = '{32'h00221820, 32'h342500FF, 32'h00031100, 32'h00231007, 32'h2822FFFF, 32'h3C021234};
        e_aluc = '{4'b0010, 4'b0101, 4'b1110, 4'b1100, 4'b1011, 4'b1000};
        e_m3   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        e_m4   = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01};
        e_m8   = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
        for (int i = 0; i < 6; i++) begin
            bus.imem_out = ins[i]; bus.im_ready = 1'b1;
            test_cnt++; if (bus.IM_R !== 1'b1) begin fail_cnt++; $display("FAIL alu%0d_fetch_im_r: got %b want 1", i, bus.IM_R); end
            tick();
            bus.im_ready = 1'b0;
            test_cnt++; if (bus.ALUC !== e_aluc[i]) begin fail_cnt++; $display("FAIL alu%0d_aluc: got %b want %b", i, bus.ALUC, e_aluc[i]); end
            test_cnt++; if ({bus.M3, bus.M4, bus.M8} !== {e_m3[i], e_m4[i], e_m8[i]}) begin fail_cnt++; $display("FAIL alu%0d_m3m4m8: got %b want %b", i, {bus.M3, bus.M4, bus.M8}, {e_m3[i], e_m4[i], e_m8[i]}); end
            test_cnt++; if ({bus.M7, bus.M2, bus.RF_W, bus.PC_W} !== 4'b1000) begin fail_cnt++; $display("FAIL alu%0d_exec_misc: got %b want 1000", i, {bus.M7, bus.M2, bus.RF_W, bus.PC_W}); end
            tick();
            test_cnt++; if ({bus.RF_W, bus.PC_W} !== 2'b11) begin fail_cnt++; $display("FAIL alu%0d_wb: got %b want 11", i, {bus.RF_W, bus.PC_W}); end
            tick();
            test_cnt++; if ({bus.IM_R, bus.PC_W} !== 2'b10) begin fail_cnt++; $display("FAIL alu%0d_refetch: got %b want 10", i, {bus.IM_R, bus.PC_W}); end
            test_cnt++; if (bus.ir_out !== ins[i]) begin fail_cnt++; $display("FAIL alu%0d_ir: got %h want %h", i, bus.ir_out, ins[i]); end
        end
    endtask

    // lw with dm_ready arriving on the 4th MEM cycle (the final counted one)
    task automatic test_lw_wait();
        bus.imem_out = 32'h8C240008; bus.im_ready = 1'b1; bus.dm_ready = 1'b0;
        tick();
        bus.im_ready = 1'b0;
        test_cnt++; if (bus.M4 !== 2'b10) begin fail_cnt++; $display("FAIL lw_exec_m4: got %b want 10", bus.M4); end
        tick();
        for (int i = 0; i < 4; i++) begin
            test_cnt++; if ({bus.CS, bus.DM_R, bus.DM_W, bus.PC_W} !== 4'b1100) begin fail_cnt++; $display("FAIL lw_mem%0d: got %b want 1100", i, {bus.CS, bus.DM_R, bus.DM_W, bus.PC_W}); end
            if (i == 3) bus.dm_ready = 1'b1;
            tick();
        end
        bus.dm_ready = 1'b0;
        test_cnt++; if ({bus.RF_W, bus.PC_W, bus.M2, bus.M8, bus.M4} !== 7'b1110110) begin fail_cnt++; $display("FAIL lw_wb: got %b want 1110110", {bus.RF_W, bus.PC_W, bus.M2, bus.M8, bus.M4}); end
        test_cnt++; if ({bus.CS, bus.trap} !== 2'b00) begin fail_cnt++; $display("FAIL lw_wb_cs_trap: got %b want 00", {bus.CS, bus.trap}); end
        tick();
        test_cnt++; if (bus.IM_R !== 1'b1) begin fail_cnt++; $display("FAIL lw_refetch: got %b want 1", bus.IM_R); end
    endtask

    // beq/bne with both Z values; M5 is low only when the branch is taken
    task automatic test_branch();
        logic [31:0] ins [0:3];
        logic        zv [0:3];
        logic        e_m5 [0:3];
        ins  = '{32'h10220004, 32'h10220004, 32'h14220004, 32'h14220004};
        zv   = '{1'b1, 1'b0, 1'b0, 1'b1};
        e_m5 = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.imem_out = ins[i]; bus.im_ready = 1'b1;
            tick();
            bus.im_ready = 1'b0; bus.Z = zv[i];
            test_cnt++; if ({bus.ALUC, bus.M4} !== 6'b000100) begin fail_cnt++; $display("FAIL br%0d_exec: got %b want 000100", i, {bus.ALUC, bus.M4}); end
            tick();
            bus.Z = 1'b0;
            test_cnt++; if ({bus.M5, bus.RF_W, bus.PC_W, bus.M1} !== {e_m5[i], 3'b010}) begin fail_cnt++; $display("FAIL br%0d_wb: got %b want %b", i, {bus.M5, bus.RF_W, bus.PC_W, bus.M1}, {e_m5[i], 3'b010}); end
            tick();
        end
    endtask

    task automatic test_jal_jr();
        bus.imem_out = 32'h0C100000; bus.im_ready = 1'b1;
        tick();
        bus.im_ready = 1'b0;
        tick();
        test_cnt++; if ({bus.M1, bus.M6, bus.M8, bus.M7, bus.RF_W, bus.PC_W} !== 7'b1010011) begin fail_cnt++; $display("FAIL jal_wb: got %b want 1010011", {bus.M1, bus.M6, bus.M8, bus.M7, bus.RF_W, bus.PC_W}); end
        tick();
        bus.imem_out = 32'h03E00008; bus.im_ready = 1'b1;
        tick();
        bus.im_ready = 1'b0;
        tick();
        test_cnt++; if ({bus.M1, bus.M6, bus.RF_W, bus.PC_W} !== 4'b1101) begin fail_cnt++; $display("FAIL jr_wb: got %b want 1101", {bus.M1, bus.M6, bus.RF_W, bus.PC_W}); end
        tick();
        test_cnt++; if (bus.IM_R !== 1'b1) begin fail_cnt++; $display("FAIL jr_refetch: got %b want 1", bus.IM_R); end
    endtask

    // Handshakes tied high: two instructions retire in six cycles
    task automatic test_back_to_back();
        int pcw = 0;
        bus.imem_out = 32'h00221820; bus.im_ready = 1'b1; bus.dm_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.PC_W === 1'b1) pcw++;
        end
        bus.im_ready = 1'b0; bus.dm_ready = 1'b0;
        test_cnt++; if (pcw !== 2) begin fail_cnt++; $display("FAIL b2b_pc_w_count: got %0d want 2", pcw); end
        test_cnt++; if (bus.IM_R !== 1'b1) begin fail_cnt++; $display("FAIL b2b_end_fetch: got %b want 1", bus.IM_R); end
    endtask

    task automatic test_illegal();
        int bad = 0;
        bus.imem_out = 32'hFC000000; bus.im_ready = 1'b1;
        tick();
        tick();
        test_cnt++; if ({bus.trap, bus.trap_cause} !== 3'b101) begin fail_cnt++; $display("FAIL ill_trap: got %b want 101", {bus.trap, bus.trap_cause}); end
        bus.dm_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if ({bus.PC_W, bus.RF_W, bus.IM_R, bus.CS, bus.M1, bus.M5, bus.M7, bus.trap} !== 8'b00000001) bad++;
            tick();
        end
        bus.im_ready = 1'b0; bus.dm_ready = 1'b0;
        test_cnt++; if (bad !== 0) begin fail_cnt++; $display("FAIL ill_hold: got %0d bad cycles want 0", bad); end
        reset = 1'b0;
        #1;
        test_cnt++; if ({bus.trap, bus.trap_cause, bus.IM_R} !== 4'b0000) begin fail_cnt++; $display("FAIL ill_reset: got %b want 0000", {bus.trap, bus.trap_cause, bus.IM_R}); end
        tick();
        reset = 1'b1;
        #1;
        test_cnt++; if (bus.IM_R !== 1'b1) begin fail_cnt++; $display("FAIL ill_refetch: got %b want 1", bus.IM_R); end
    endtask

    task automatic test_sw_timeout();
        bus.imem_out = 32'hAC220004; bus.im_ready = 1'b1; bus.dm_ready = 1'b0;
        tick();
        bus.im_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            test_cnt++; if ({bus.CS, bus.DM_W, bus.DM_R, bus.PC_W} !== 4'b1100) begin fail_cnt++; $display("FAIL sw_mem%0d: got %b want 1100", i, {bus.CS, bus.DM_W, bus.DM_R, bus.PC_W}); end
            tick();
        end
        test_cnt++; if ({bus.trap, bus.trap_cause} !== 3'b110) begin fail_cnt++; $display("FAIL sw_to_trap: got %b want 110", {bus.trap, bus.trap_cause}); end
        test_cnt++; if ({bus.DM_W, bus.CS, bus.PC_W, bus.RF_W} !== 4'b0000) begin fail_cnt++; $display("FAIL sw_to_strobes: got %b want 0000", {bus.DM_W, bus.CS, bus.PC_W, bus.RF_W}); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    // Reset while waiting in MEM aborts the lw with no write-back
    task automatic test_reset_mid_mem();
        int wr = 0;
        bus.imem_out = 32'h8C240008; bus.im_ready = 1'b1; bus.dm_ready = 1'b0;
        tick();
        bus.im_ready = 1'b0;
        tick();
        tick();
        test_cnt++; if ({bus.CS, bus.DM_R} !== 2'b11) begin fail_cnt++; $display("FAIL mid_in_mem: got %b want 11", {bus.CS, bus.DM_R}); end
        reset = 1'b0;
        #1;
        test_cnt++; if ({bus.CS, bus.DM_R, bus.PC_W, bus.RF_W} !== 4'b0000) begin fail_cnt++; $display("FAIL mid_reset_strobes: got %b want 0000", {bus.CS, bus.DM_R, bus.PC_W, bus.RF_W}); end
        bus.dm_ready = 1'b1;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ((bus.PC_W | bus.RF_W | bus.CS) === 1'b1) wr++;
        end
        bus.dm_ready = 1'b0;
        test_cnt++; if (wr !== 0) begin fail_cnt++; $display("FAIL mid_no_wb: got %0d write cycles want 0", wr); end
        test_cnt++; if ({bus.IM_R, bus.ir_out} !== {1'b1, 32'd0}) begin fail_cnt++; $display("FAIL mid_after: got %b/%h want 1/00000000", bus.IM_R, bus.ir_out); end
    endtask

    initial begin
        test_reset();
        test_alu_decode();
        test_lw_wait();
        test_branch();
        test_jal_jr();
        test_back_to_back();
        test_illegal();
        test_sw_timeout();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
